// File: rtl/osd_register_bank_pkg.sv
// Shared types, register map and video mode helpers for the OSD register bank.
package osd_regs_pkg;

  typedef logic [11:0] ControllerData;

  typedef struct packed {
    logic [8:0] intensity;
    logic       thickness;
    logic       oddeven;
    logic       active;
  } Scanline;

  localparam Scanline SCANLINE_RESET = '{intensity: 9'h100, thickness: 1'b0,
                                         oddeven: 1'b0, active: 1'b0};

  localparam logic [7:0] REG_PAGE      = 8'h80;
  localparam logic [7:0] REG_ENABLE    = 8'h81;
  localparam logic [7:0] REG_HIGHLIGHT = 8'h82;
  localparam logic [7:0] REG_RECONF    = 8'h83;
  localparam logic [7:0] REG_MODE      = 8'h84;
  localparam logic [7:0] REG_CTRL_HI   = 8'h85;
  localparam logic [7:0] REG_CTRL_LO   = 8'h86;
  localparam logic [7:0] REG_SCAN_HI   = 8'h87;
  localparam logic [7:0] REG_SCAN_LO   = 8'h88;
  localparam logic [7:0] REG_COMMIT    = 8'h89;
  localparam logic [7:0] REG_RESET_DC  = 8'hF0;

  localparam logic [3:0] MODE_1080P = 4'd0;
  localparam logic [3:0] MODE_960P  = 4'd1;
  localparam logic [3:0] MODE_480P  = 4'd2;
  localparam logic [3:0] MODE_VGA   = 4'd3;

  typedef enum logic [1:0] {C_IDLE = 2'd0, C_PENDING = 2'd1, C_APPLY = 2'd2} commit_state_e;

  typedef struct packed {
    logic [11:0] h_active;
    logic [10:0] v_active;
    logic        pixel_double;
  } HDMIVideoConfig;

  function automatic HDMIVideoConfig decode_mode(input logic [3:0] mode);
    HDMIVideoConfig c;
    case (mode)
      MODE_1080P: c = '{h_active: 12'd1920, v_active: 11'd1080, pixel_double: 1'b0};
      MODE_960P:  c = '{h_active: 12'd1280, v_active: 11'd960,  pixel_double: 1'b0};
      MODE_480P:  c = '{h_active: 12'd720,  v_active: 11'd480,  pixel_double: 1'b1};
      default:    c = '{h_active: 12'd640,  v_active: 11'd480,  pixel_double: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/osd_register_bank_if.sv
// Byte-wide register bus between the i2c slave (master side) and the register bank.
// writeEn is a level; a byte is written once on its rising edge. readEn is a one-cycle
// strobe telling the bank the byte at addr was handed over. dataOut follows addr one cycle later.
interface osd_register_bank_if;
  logic [7:0] addr;
  logic [7:0] dataIn;
  logic       writeEn;
  logic       readEn;
  logic [7:0] dataOut;

  modport master (output addr, dataIn, writeEn, readEn, input dataOut);
  modport slave  (input addr, dataIn, writeEn, readEn, output dataOut);
endinterface

// File: rtl/osd_register_bank_pulse_timer.sv
// Retriggerable fixed-length pulse: load (re)starts a CYCLES-long busy window.
module pulse_timer #(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic busy
);
  localparam int W = $clog2(CYCLES + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)                count <= '0;
    else if (load)            count <= W'(CYCLES);
    else if (count != '0)     count <= count - W'(1);
  end

  assign busy = (count != '0);
endmodule

// File: rtl/osd_register_bank.sv
// I2C-facing register bank: paged OSD RAM writes, control registers, double-buffered
// video config with atomic commit, coherent controller snapshot and Dreamcast reset pulse.
module osd_register_bank
  import osd_regs_pkg::*;
#(
  parameter int unsigned PAGE_BITS          = 3,
  parameter int unsigned NUM_MODES          = 4,
  parameter bit          COMMIT_ON_VSYNC    = 1'b1,
  parameter int unsigned RESET_PULSE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  osd_register_bank_if.slave     bus,
  input  logic                   vsync,
  input  ControllerData          controller_data,
  output logic [7:0]             ram_dataIn,
  output logic [PAGE_BITS+6:0]   ram_wraddress,
  output logic                   ram_wren,
  output logic                   enable_osd,
  output logic [7:0]             highlight_line,
  output logic [7:0]             reconf_data,
  output logic [3:0]             video_mode,
  output Scanline                scanline,
  output logic                   config_update,
  output logic                   reset_dc,
  output commit_state_e          commit_state
);

  logic                 writeEn_q, vsync_q;
  logic                 wr, vsync_rise, commit_req, apply, mode_ok;
  logic [PAGE_BITS-1:0] page;
  logic [7:0]           sh_reconf;
  logic [3:0]           sh_mode;
  Scanline              sh_scan;
  logic [3:0]           snap;
  logic [7:0]           rd_byte;
  commit_state_e        state, state_next;

  assign wr         = bus.writeEn & ~writeEn_q;
  assign vsync_rise = vsync & ~vsync_q;
  assign commit_req = wr && (bus.addr == REG_COMMIT);
  assign mode_ok    = 32'(bus.dataIn[3:0]) < NUM_MODES;
  assign commit_state = state;

  always_ff @(posedge clk) begin
    if (reset) state <= C_IDLE;
    else       state <= state_next;
  end

  // Commits arriving while PENDING/APPLY merge into the one already in flight.
  always_comb begin
    state_next = state;
    apply      = 1'b0;
    case (state)
      C_IDLE:    if (commit_req) state_next = C_PENDING;
      C_PENDING: if (!COMMIT_ON_VSYNC || vsync_rise) state_next = C_APPLY;
      C_APPLY: begin
        apply      = 1'b1;
        state_next = C_IDLE;
      end
      default:   state_next = C_IDLE;
    endcase
  end

  always_comb begin
    rd_byte = '0;
    case (bus.addr)
      REG_PAGE:      rd_byte = 8'(page);
      REG_ENABLE:    rd_byte = {7'b0, enable_osd};
      REG_HIGHLIGHT: rd_byte = highlight_line;
      REG_RECONF:    rd_byte = sh_reconf;
      REG_MODE:      rd_byte = {4'b0, video_mode};
      REG_CTRL_HI:   rd_byte = controller_data[11:4];
      REG_CTRL_LO:   rd_byte = {snap, 4'b0};
      REG_SCAN_HI:   rd_byte = sh_scan.intensity[8:1];
      REG_SCAN_LO:   rd_byte = {sh_scan.intensity[0], sh_scan.thickness,
                                sh_scan.oddeven, sh_scan.active, 4'b0};
      REG_COMMIT:    rd_byte = {state != C_IDLE, reset_dc, 6'b0};
      default:       rd_byte = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      writeEn_q      <= 1'b0;
      vsync_q        <= 1'b0;
      bus.dataOut    <= '0;
      ram_wren       <= 1'b0;
      ram_dataIn     <= '0;
      ram_wraddress  <= '0;
      page           <= '0;
      enable_osd     <= 1'b0;
      highlight_line <= 8'hFF;
      sh_reconf      <= '0;
      sh_mode        <= MODE_1080P;
      sh_scan        <= SCANLINE_RESET;
      reconf_data    <= '0;
      video_mode     <= MODE_1080P;
      scanline       <= SCANLINE_RESET;
      config_update  <= 1'b0;
      snap           <= '0;
    end else begin
      writeEn_q     <= bus.writeEn;
      vsync_q       <= vsync;
      bus.dataOut   <= rd_byte;
      ram_wren      <= wr && (bus.addr < REG_PAGE);
      config_update <= apply;
      if (wr && (bus.addr < REG_PAGE)) begin
        ram_wraddress <= {page, bus.addr[6:0]};
        ram_dataIn    <= bus.dataIn;
      end
      if (bus.readEn && (bus.addr == REG_CTRL_HI)) snap <= controller_data[3:0];
      // APPLY samples the shadow before any same-cycle shadow write lands.
      if (apply) begin
        video_mode  <= sh_mode;
        reconf_data <= sh_reconf;
        scanline    <= sh_scan;
      end
      if (wr) begin
        case (bus.addr)
          REG_PAGE:      page <= bus.dataIn[PAGE_BITS-1:0];
          REG_ENABLE:    enable_osd <= bus.dataIn[0];
          REG_HIGHLIGHT: highlight_line <= bus.dataIn;
          REG_RECONF: begin
            sh_reconf <= bus.dataIn;
            if (mode_ok) sh_mode <= bus.dataIn[3:0];
          end
          REG_SCAN_HI:   sh_scan.intensity[8:1] <= bus.dataIn;
          REG_SCAN_LO: begin
            sh_scan.intensity[0] <= bus.dataIn[7];
            sh_scan.thickness    <= bus.dataIn[6];
            sh_scan.oddeven      <= bus.dataIn[5];
            sh_scan.active       <= bus.dataIn[4];
          end
          default: ;
        endcase
      end
    end
  end

  pulse_timer #(.CYCLES(RESET_PULSE_CYCLES)) u_reset_timer (
    .clk   (clk),
    .reset (reset),
    .load  (wr && (bus.addr == REG_RESET_DC)),
    .busy  (reset_dc)
  );

endmodule

// File: tb/tb_osd_register_bank.sv
// Bench for osd_register_bank: two instances (commit on vsync / immediate commit) driven
// by shared stimulus and compared every cycle with a register-map reference model.
module tb_osd_register_bank;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  b_addr = '0, b_din = '0;
  logic        b_wen = 1'b0, b_ren = 1'b0, vsync = 1'b0;
  logic [11:0] cdata = '0;

  osd_register_bank_if if0 ();
  osd_register_bank_if if1 ();
  assign if0.addr = b_addr;  assign if0.dataIn = b_din;
  assign if0.writeEn = b_wen; assign if0.readEn = b_ren;
  assign if1.addr = b_addr;  assign if1.dataIn = b_din;
  assign if1.writeEn = b_wen; assign if1.readEn = b_ren;

  logic [7:0]  o_dout [2];
  logic [7:0]  o_ram_din [2];
  logic [9:0]  o_ram_addr [2];
  logic        o_ram_wren [2], o_en [2], o_cfg [2], o_rdc [2];
  logic [7:0]  o_hl [2], o_reconf [2];
  logic [3:0]  o_mode [2];
  logic [11:0] o_scan [2];
  logic [1:0]  o_state [2];
  assign o_dout[0] = if0.dataOut;
  assign o_dout[1] = if1.dataOut;

  osd_register_bank #(.COMMIT_ON_VSYNC(1'b1)) dut0 (
    .clk(clk), .reset(rst), .bus(if0), .vsync(vsync), .controller_data(cdata),
    .ram_dataIn(o_ram_din[0]), .ram_wraddress(o_ram_addr[0]), .ram_wren(o_ram_wren[0]),
    .enable_osd(o_en[0]), .highlight_line(o_hl[0]), .reconf_data(o_reconf[0]),
    .video_mode(o_mode[0]), .scanline(o_scan[0]), .config_update(o_cfg[0]),
    .reset_dc(o_rdc[0]), .commit_state(o_state[0]));

  osd_register_bank #(.COMMIT_ON_VSYNC(1'b0)) dut1 (
    .clk(clk), .reset(rst), .bus(if1), .vsync(vsync), .controller_data(cdata),
    .ram_dataIn(o_ram_din[1]), .ram_wraddress(o_ram_addr[1]), .ram_wren(o_ram_wren[1]),
    .enable_osd(o_en[1]), .highlight_line(o_hl[1]), .reconf_data(o_reconf[1]),
    .video_mode(o_mode[1]), .scanline(o_scan[1]), .config_update(o_cfg[1]),
    .reset_dc(o_rdc[1]), .commit_state(o_state[1]));

  // ---------------- scoreboard ----------------
  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Register-map view: shadow fields as integers, commit as "pending" / "applies next edge".
  bit model_valid = 0;
  int m_page, m_en, m_hl, m_sh_reconf, m_sh_mode, m_int, m_thick, m_oe, m_act;
  int m_ram_wren, m_ram_addr, m_ram_din, m_snap, m_rst_left;
  bit m_wen_prev, m_vs_prev;
  int m_mode [2], m_reconf [2], m_scan [2], m_cfg [2], m_dout [2];
  bit m_pending [2], m_apply [2];
  bit t_wr, t_vs_rise, t_was_p, t_was_a, t_cov;
  logic [7:0] t_a, t_d;

  function automatic int read_model(input logic [7:0] a, input int i, input bit pend);
    case (a)
      8'h80: return m_page;
      8'h81: return m_en;
      8'h82: return m_hl;
      8'h83: return m_sh_reconf;
      8'h84: return m_mode[i];
      8'h85: return int'(cdata) / 16;
      8'h86: return m_snap * 16;
      8'h87: return m_int / 2;
      8'h88: return (m_int % 2) * 128 + m_thick * 64 + m_oe * 32 + m_act * 16;
      8'h89: return (pend ? 128 : 0) + ((m_rst_left != 0) ? 64 : 0);
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    t_a = b_addr; t_d = b_din;
    t_wr = b_wen && !m_wen_prev;
    t_vs_rise = vsync && !m_vs_prev;
    if (rst) begin
      m_page = 0; m_en = 0; m_hl = 255; m_sh_reconf = 0; m_sh_mode = 0;
      m_int = 256; m_thick = 0; m_oe = 0; m_act = 0;
      m_ram_wren = 0; m_ram_addr = 0; m_ram_din = 0; m_snap = 0; m_rst_left = 0;
      m_wen_prev = 0; m_vs_prev = 0;
      for (int i = 0; i < 2; i++) begin
        m_mode[i] = 0; m_reconf[i] = 0; m_scan[i] = 12'h800; m_cfg[i] = 0;
        m_dout[i] = 0; m_pending[i] = 0; m_apply[i] = 0;
      end
      model_valid = 1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        t_cov = (i == 0);
        t_was_p = m_pending[i];
        t_was_a = m_apply[i];
        m_dout[i] = read_model(t_a, i, t_was_p || t_was_a);
        m_cfg[i] = t_was_a ? 1 : 0;
        if (t_was_a) begin
          m_mode[i]   = m_sh_mode;
          m_reconf[i] = m_sh_reconf;
          m_scan[i]   = m_int * 8 + m_thick * 4 + m_oe * 2 + m_act;
        end
        m_apply[i]   = t_was_p && (!t_cov || t_vs_rise);
        m_pending[i] = t_was_p && !m_apply[i];
        if (t_wr && t_a == 8'h89 && !t_was_p && !t_was_a) m_pending[i] = 1;
      end
      m_ram_wren = (t_wr && t_a < 8'h80) ? 1 : 0;
      if (m_ram_wren == 1) begin
        m_ram_addr = m_page * 128 + int'(t_a) % 128;
        m_ram_din  = t_d;
      end
      if (b_ren && t_a == 8'h85) m_snap = int'(cdata) % 16;
      if (t_wr && t_a == 8'hF0) m_rst_left = 16;
      else if (m_rst_left > 0) m_rst_left--;
      if (t_wr) begin
        case (t_a)
          8'h80: m_page = t_d % 8;
          8'h81: m_en = t_d % 2;
          8'h82: m_hl = t_d;
          8'h83: begin
            m_sh_reconf = t_d;
            if (t_d % 16 < 4) m_sh_mode = t_d % 16;
          end
          8'h87: m_int = (m_int % 2) + int'(t_d) * 2;
          8'h88: begin
            m_int   = (m_int / 2) * 2 + int'(t_d[7]);
            m_thick = t_d[6]; m_oe = t_d[5]; m_act = t_d[4];
          end
          default: ;
        endcase
      end
      m_wen_prev = b_wen;
      m_vs_prev  = vsync;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("dataOut[%0d]", i),       32'(o_dout[i]),     m_dout[i]);
        check($sformatf("ram_wren[%0d]", i),      32'(o_ram_wren[i]), m_ram_wren);
        check($sformatf("ram_wraddress[%0d]", i), 32'(o_ram_addr[i]), m_ram_addr);
        check($sformatf("ram_dataIn[%0d]", i),    32'(o_ram_din[i]),  m_ram_din);
        check($sformatf("enable_osd[%0d]", i),    32'(o_en[i]),       m_en);
        check($sformatf("highlight[%0d]", i),     32'(o_hl[i]),       m_hl);
        check($sformatf("reconf_data[%0d]", i),   32'(o_reconf[i]),   m_reconf[i]);
        check($sformatf("video_mode[%0d]", i),    32'(o_mode[i]),     m_mode[i]);
        check($sformatf("scanline[%0d]", i),      32'(o_scan[i]),     m_scan[i]);
        check($sformatf("config_update[%0d]", i), 32'(o_cfg[i]),      m_cfg[i]);
        check($sformatf("reset_dc[%0d]", i),      32'(o_rdc[i]),      (m_rst_left != 0) ? 1 : 0);
      end
    end
  end

  // Event counters sampled just after each active edge.
  int wren_cnt = 0, rdc_cnt = 0;
  int cfg_cnt [2] = '{0, 0};
  always @(posedge clk) begin
    #1;
    if (o_ram_wren[0]) wren_cnt++;
    if (o_rdc[0]) rdc_cnt++;
    for (int i = 0; i < 2; i++) if (o_cfg[i]) cfg_cnt[i]++;
  end

  // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
  task automatic wr_byte(input logic [7:0] a, input logic [7:0] d, input int hold);
    b_addr = a; b_din = d; b_wen = 1'b1;
    repeat (hold) @(negedge clk);
    b_wen = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd_byte(input logic [7:0] a, output logic [7:0] d);
    b_addr = a; b_ren = 1'b1;
    @(negedge clk);
    b_ren = 1'b0;
    d = o_dout[0];
  endtask

  // ---------------- directed + random stimulus ----------------
  logic [7:0] rd;
  int pick;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset dataOut",   32'(o_dout[0]),   0);
    check("reset highlight", 32'(o_hl[0]),     32'hFF);
    check("reset scanline",  32'(o_scan[0]),   32'h800);
    check("reset video_mode", 32'(o_mode[0]),  0);
    check("reset reset_dc",  32'(o_rdc[0]),    0);

    // paged RAM write; a long writeEn hold still yields one strobe
    wr_byte(8'h80, 8'h05, 1);
    wren_cnt = 0;
    wr_byte(8'h12, 8'hAB, 10);
    check("ram single wren",  32'(wren_cnt),      1);
    check("ram wraddress",    32'(o_ram_addr[0]), 32'h292);
    check("ram dataIn",       32'(o_ram_din[0]),  32'hAB);

    // commit waits for vsync on dut0
    vsync = 1'b0;
    wr_byte(8'h83, 8'h02, 1);
    wr_byte(8'h88, 8'hF0, 1);
    wr_byte(8'h89, 8'h00, 1);
    rd_byte(8'h89, rd);
    check("read 89 pending", 32'(rd), 32'h80);
    check("mode before vsync", 32'(o_mode[0]), 0);
    cfg_cnt[0] = 0;
    vsync = 1'b1;
    repeat (2) @(negedge clk);
    check("mode after vsync", 32'(o_mode[0]), 2);
    check("scanline active", 32'(o_scan[0][0]), 1);
    check("config_update pulse", 32'(o_cfg[0]), 1);
    @(negedge clk);
    check("config_update once", 32'(cfg_cnt[0]), 1);
    rd_byte(8'h89, rd);
    check("read 89 idle", 32'(rd), 0);
    vsync = 1'b0;

    // invalid mode index keeps the old mode but still commits reconf
    wr_byte(8'h83, 8'h07, 1);
    rd_byte(8'h83, rd);
    check("read 83", 32'(rd), 32'h07);
    wr_byte(8'h89, 8'h00, 1);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    check("invalid mode kept", 32'(o_mode[0]), 2);
    check("reconf committed", 32'(o_reconf[0]), 32'h07);

    // controller snapshot coherency
    cdata = 12'hABC;
    rd_byte(8'h85, rd);
    check("read 85", 32'(rd), 32'hAB);
    cdata = 12'h123;
    rd_byte(8'h86, rd);
    check("read 86 snap", 32'(rd), 32'hC0);

    // reset_dc: plain pulse, retrigger after 10 high cycles, cut by reset
    rdc_cnt = 0;
    wr_byte(8'hF0, 8'h00, 1);
    repeat (24) @(negedge clk);
    check("reset_dc 16 cycles", 32'(rdc_cnt), 16);
    rdc_cnt = 0;
    wr_byte(8'hF0, 8'h00, 1);
    repeat (8) @(negedge clk);
    wr_byte(8'hF0, 8'h00, 1);
    repeat (30) @(negedge clk);
    check("reset_dc retrigger 26", 32'(rdc_cnt), 26);
    wr_byte(8'hF0, 8'h00, 1);
    repeat (3) @(negedge clk);
    check("reset_dc before reset", 32'(o_rdc[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset_dc cut by reset", 32'(o_rdc[0]), 0);

    // immediate commit on dut1; a second commit during APPLY merges
    wr_byte(8'h87, 8'h40, 1);
    cfg_cnt[1] = 0;
    wr_byte(8'h89, 8'h00, 1);
    check("scan not yet applied", 32'(o_scan[1]), 32'h800);
    wr_byte(8'h89, 8'h00, 1);
    check("scan intensity 0x080", 32'(o_scan[1][11:3]), 32'h080);
    repeat (4) @(negedge clk);
    check("single config_update", 32'(cfg_cnt[1]), 1);

    // randomized traffic
    repeat (3000) begin
      @(negedge clk);
      rst = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 2) == 0) b_wen = ~b_wen;
      pick = $urandom_range(0, 19);
      if (pick < 6)       b_addr = 8'($urandom_range(0, 127));
      else if (pick < 17) b_addr = 8'h80 + 8'($urandom_range(0, 9));
      else if (pick < 18) b_addr = 8'hF0;
      else                b_addr = 8'($urandom_range(0, 255));
      b_din = 8'($urandom_range(0, 255));
      b_ren = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) vsync = ~vsync;
      cdata = 12'($urandom_range(0, 4095));
    end
    @(negedge clk);
    rst = 1'b0; b_wen = 1'b0; b_ren = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
